// File: rtl/vc_link_arbiter.sv
// Wormhole arbiter: VC lanes share one registered flit link, head-to-tail locking with round-robin.
// Optional VC0_PRIORITY_EN: lane 0 wins idle arbitration outright and never advances rr_ptr.

module vc_lane_dec (
    input  logic       valid,
    input  logic [1:0] ftype,
    input  logic       owned,
    output logic       head,
    output logic       err
);
    assign head = valid && (ftype == 2'b01);
    // a non-head flit is only legal from the lane currently holding the link
    assign err  = valid && (ftype != 2'b01) && !owned;
endmodule

module vc_link_arbiter #(
    parameter  int VC         = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int VCW        = $clog2(VC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VC*DATA_WIDTH-1:0] in_data,
    input  logic [VC-1:0]            in_valid,
    output logic [VC-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [VCW-1:0]           out_vc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     proto_err
);
    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [VCW:0]   VC_L = (VCW+1)'(VC);
    localparam logic [VCW-1:0] LAST = VCW'(VC - 1);

    state_t                state, state_nx;
    logic [VCW-1:0]        gnt, gnt_nx, rr_ptr, rr_nx, gnt_inc;
    logic [VCW-1:0]        win, sel;
    logic                  win_vld, slot_free, xfer;
    logic [VC-1:0]         head, err, owned, cand;
    logic [VCW:0]          idx;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic [1:0]            sel_type;

    genvar g;
    generate
        for (g = 0; g < VC; g++) begin : g_lane
            assign owned[g] = (state == LOCK) && (gnt == VCW'(g));
            vc_lane_dec u_dec (
                .valid (in_valid[g]),
                .ftype (in_data[g*DATA_WIDTH + DATA_WIDTH - 1 -: 2]),
                .owned (owned[g]),
                .head  (head[g]),
                .err   (err[g])
            );
        end
    endgenerate

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state == LOCK);

    // first eligible head searching rr_ptr, rr_ptr+1, ... modulo VC
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        cand    = head;
`ifdef VC0_PRIORITY_EN
        cand[0] = 1'b0;
        if (head[0]) win_vld = 1'b1;
`endif
        for (int i = 0; i < VC; i++) begin
            idx = {1'b0, rr_ptr} + (VCW+1)'(i);
            if (idx >= VC_L) idx = idx - VC_L;
            if (!win_vld && cand[idx[VCW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[VCW-1:0];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst) begin
            if (state == LOCK)  in_ready[gnt] = slot_free;
            else if (win_vld)   in_ready[win] = slot_free;
        end
    end

    assign sel      = (state == LOCK) ? gnt : win;
    assign sel_flit = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
    assign sel_type = sel_flit[DATA_WIDTH-1 -: 2];
    assign xfer     = |(in_valid & in_ready);
    assign gnt_inc  = (gnt == LAST) ? '0 : gnt + 1'b1;

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        rr_nx    = rr_ptr;
        case (state)
            IDLE: if (xfer) begin
                state_nx = LOCK;
                gnt_nx   = win;
            end
            LOCK: if (xfer && sel_type == 2'b11) begin
                state_nx = IDLE;
`ifdef VC0_PRIORITY_EN
                if (gnt != '0) rr_nx = gnt_inc;
`else
                rr_nx = gnt_inc;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            out_data  <= '0;
            out_vc    <= '0;
            out_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state  <= state_nx;
            gnt    <= gnt_nx;
            rr_ptr <= rr_nx;
            if (xfer) begin
                out_data  <= sel_flit;
                out_vc    <= sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (|err) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vc_link_arbiter.sv
// Randomized and directed bench for vc_link_arbiter against a cycle reference model of the lane/link rules.
module tb_vc_link_arbiter;
    localparam int VC  = 4;
    localparam int DW  = 32;
    localparam int VCW = 2;
`ifdef VC0_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [VC*DW-1:0]  in_data = '0;
    logic [VC-1:0]     in_valid = '0;
    logic [VC-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic [VCW-1:0]    out_vc;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy, proto_err;

    vc_link_arbiter #(.VC(VC), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_vc(out_vc), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] lq [VC][$];
    int vpct = 100, ormode = 1, cnum = 0, pid = 0;
    int m_owner = -1, m_rr = 0, m_ovc = 0;
    bit m_ov = 0, m_perr = 0;
    logic [DW-1:0] m_od = '0;
    logic [VC-1:0] exp_rdy, act_rdy;
    logic [DW-1:0] dq_d[$];
    int dq_v[$], dq_t[$];
    logic [DW-1:0] exp_pkt[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cnum);
        end
    endtask

    function automatic logic [DW-1:0] lane_flit(input int v);
        return in_data[v*DW +: DW];
    endfunction

    function automatic bit is_head(input logic [DW-1:0] f);
        return f[DW-1:DW-2] == 2'b01;
    endfunction

    task automatic add_pkt(input int v, input int nbody);
        pid++;
        lq[v].push_back({2'b01, 6'(v), 24'(pid)});
        for (int i = 0; i < nbody; i++) lq[v].push_back({2'b10, 30'($urandom)});
        lq[v].push_back({2'b11, 6'(v), 24'(pid)});
    endtask

    task automatic model_comb();
        bit sf;
        int w;
        sf = !m_ov || out_ready;
        exp_rdy = '0;
        w = -1;
        if (!rst) return;
        if (m_owner >= 0) exp_rdy[m_owner] = sf;
        else begin
            if (PRIO && in_valid[0] && is_head(lane_flit(0))) w = 0;
            for (int k = 0; k < VC && w < 0; k++) begin
                int v;
                v = (m_rr + k) % VC;
                if (PRIO && v == 0) continue;
                if (in_valid[v] && is_head(lane_flit(v))) w = v;
            end
            if (w >= 0) exp_rdy[w] = sf;
        end
    endtask

    task automatic model_seq();
        int x;
        logic [DW-1:0] f;
        x = -1;
        for (int v = 0; v < VC; v++) begin
            if (in_valid[v] && exp_rdy[v]) x = v;
            if (in_valid[v] && !is_head(lane_flit(v)) && v != m_owner) m_perr = 1;
            if (in_valid[v] && act_rdy[v] && lq[v].size() > 0) void'(lq[v].pop_front());
        end
        if (x >= 0) begin
            f = lane_flit(x);
            m_od = f; m_ovc = x; m_ov = 1;
            if (m_owner < 0) m_owner = x;
            else if (f[DW-1:DW-2] == 2'b11) begin
                if (!(PRIO && m_owner == 0)) m_rr = (m_owner + 1) % VC;
                m_owner = -1;
            end
        end else if (out_ready) m_ov = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        for (int v = 0; v < VC; v++) begin
            if (lq[v].size() > 0 && $urandom_range(99) < vpct) begin
                in_valid[v] = 1'b1;
                in_data[v*DW +: DW] = lq[v][0];
            end else begin
                in_valid[v] = 1'b0;
                in_data[v*DW +: DW] = '0;
            end
        end
        out_ready = (ormode == 2) ? ($urandom_range(99) < 70) : (ormode == 1);
        #1;
        model_comb();
        act_rdy = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_vc", out_vc, m_ovc);
        chk("busy", busy, m_owner >= 0);
        chk("proto_err", proto_err, m_perr);
        if (out_valid && out_ready) begin
            dq_d.push_back(out_data); dq_v.push_back(out_vc); dq_t.push_back(cnum);
        end
        @(posedge clk);
        model_seq();
        cnum++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_vc", out_vc, 0);
        in_valid = '0; in_data = '0;
        for (int v = 0; v < VC; v++) lq[v].delete();
        m_owner = -1; m_rr = 0; m_ov = 0; m_perr = 0; m_od = '0; m_ovc = 0;
        dq_d.delete(); dq_v.delete(); dq_t.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int pend, vc3;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_in_ready", in_ready, 0);
        @(negedge clk); rst = 1'b1;

        // single packet on lane 2
        lq[2].push_back(32'h40010005); lq[2].push_back(32'h80010000); lq[2].push_back(32'hC0010000);
        run(6);
        chk("single_cnt", dq_d.size(), 3);
        if (dq_d.size() >= 3) begin
            chk("single_d0", dq_d[0], 32'h40010005);
            chk("single_d1", dq_d[1], 32'h80010000);
            chk("single_d2", dq_d[2], 32'hC0010000);
            chk("single_vc", {dq_v[0][7:0], dq_v[1][7:0], dq_v[2][7:0]}, 24'h020202);
            chk("single_gap", dq_t[2] - dq_t[0], 2);
        end
        chk("single_busy", busy, 0);

        // contention lanes 1 and 3 from rr_ptr = 0
        reset_mid();
        add_pkt(1, 1); add_pkt(3, 1);
        run(10);
        chk("cont_cnt", dq_v.size(), 6);
        if (dq_v.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("cont_vc", dq_v[i], (i < 3) ? 1 : 3);
            chk("cont_b2b", dq_t[5] - dq_t[0], 5);
        end

        // backpressure mid-packet
        reset_mid();
        add_pkt(1, 4);
        foreach (lq[1][i]) exp_pkt.push_back(lq[1][i]);
        ormode = 1; run(3);
        ormode = 0; run(4);
        ormode = 1; run(8);
        chk("bp_cnt", dq_d.size(), 6);
        if (dq_d.size() >= 6)
            for (int i = 0; i < 6; i++) chk("bp_data", dq_d[i], exp_pkt[i]);

        // priority: lane 0 and lane 1 heads after a lane-0 packet
        reset_mid();
        add_pkt(0, 1);
        run(6);
        dq_v.delete(); dq_d.delete(); dq_t.delete();
        add_pkt(0, 1); add_pkt(1, 1);
        run(10);
        chk("prio_cnt", dq_v.size(), 6);
        if (dq_v.size() >= 6) begin
            chk("prio_first", dq_v[0], PRIO ? 0 : 1);
            chk("prio_second", dq_v[3], PRIO ? 1 : 0);
        end

        // protocol error: lane 3 shows a body while idle
        reset_mid();
        lq[3].push_back(32'h80020000);
        add_pkt(1, 1);
        run(10);
        chk("perr_flag", proto_err, 1);
        vc3 = 0;
        foreach (dq_v[i]) if (dq_v[i] == 3) vc3++;
        chk("perr_no_lane3", vc3, 0);
        chk("perr_lane1_cnt", dq_v.size(), 3);

        // async reset mid-packet then a fresh head
        reset_mid();
        add_pkt(2, 6);
        run(3);
        chk("mid_busy", busy, 1);
        reset_mid();
        add_pkt(3, 1);
        run(6);
        chk("post_rst_cnt", dq_v.size(), 3);
        if (dq_v.size() >= 1) chk("post_rst_vc", dq_v[0], 3);

        // randomized traffic with random link backpressure
        reset_mid();
        vpct = 70; ormode = 2;
        for (int c = 0; c < 3000; c++) begin
            for (int v = 0; v < VC; v++)
                if (lq[v].size() == 0 && $urandom_range(9) == 0) add_pkt(v, $urandom_range(3));
            cyc();
        end
        vpct = 100; ormode = 1;
        for (int c = 0; c < 300; c++) begin
            pend = 0;
            for (int v = 0; v < VC; v++) pend += lq[v].size();
            if (pend == 0 && !m_ov && m_owner < 0) break;
            cyc();
        end
        pend = 0;
        for (int v = 0; v < VC; v++) pend += lq[v].size();
        chk("drain_pending", pend, 0);
        chk("drain_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vc_link_arbiter.md
# vc_link_arbiter

Packet-level (wormhole) arbiter that shares one physical 32-bit flit link among VC virtual-channel input lanes inside a router port. Each lane presents flits with a valid/ready handshake. The arbiter grants the link to one lane from head flit to tail flit, tags every forwarded flit with its lane number, and drives the link through a single registered output stage. It replaces time-slot plane selection with demand-driven, round-robin sharing.

## Interface
- VC, 4: number of virtual-channel lanes, 2..16.
- DATA_WIDTH, 32: flit width. The type field is bits [DATA_WIDTH-1 : DATA_WIDTH-2]: 01 = head, 10 = body, 11 = tail.
- VCW, $clog2(VC): lane-index width (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low; asserting low clears all state immediately.
- in_data  in  VC*DATA_WIDTH  flat lane bus; lane v occupies [v*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  VC  per-lane flit valid.
- in_ready  out  VC  per-lane accept; combinational.
- out_data  out  DATA_WIDTH  registered link flit.
- out_vc  out  VCW  registered lane tag of out_data.
- out_valid  out  1  registered link valid.
- out_ready  in  1  link accept.
- busy  out  1  high while state = LOCK.
- proto_err  out  1  sticky; set when a lane presents a non-head flit while not granted. Cleared only by reset.

## Operation
- A lane transfers a flit when in_valid[v] & in_ready[v]. The link transfers when out_valid & out_ready.
- slot_free = !out_valid | out_ready.
- FSM has two states:
  - IDLE: no packet owns the link.
  - LOCK: lane gnt owns the link until its tail flit is accepted.
- In IDLE, a lane is eligible when in_valid[v] = 1 and its flit type is 01.
  - The winner is the first eligible lane searching rr_ptr, rr_ptr+1, … modulo VC.
  - The winner gets in_ready = slot_free in the same cycle, so the head flit is accepted in the arbitration cycle.
  - On head acceptance: gnt <= winner and state <= LOCK.
  - If no slot is free, no state change occurs. Arbitration is re-evaluated the next cycle, so the winner may change.
- In LOCK, only lane gnt sees in_ready = slot_free; every other in_ready is 0.
  - Body and head-type flits from gnt are forwarded unchanged.
  - When a tail (11) is accepted: state <= IDLE and rr_ptr <= (gnt+1) mod VC.
- Output stage: on any lane transfer, out_data <= flit, out_vc <= lane, out_valid <= 1. Otherwise, if out_ready, out_valid <= 0.
- proto_err is set on any cycle where in_valid[v] = 1 with type ≠ 01 and v is not the locked lane. Such a lane is never granted; it stalls until it presents a head.
- Reset values: out_data = 0, out_vc = 0, out_valid = 0, in_ready = 0, busy = 0, proto_err = 0, state = IDLE, gnt = 0, rr_ptr = 0.
- Reset mid-packet abandons the packet. After reset, the lanes must resume at a head flit.

## Timing
- Latency: a flit accepted at edge N appears on out_data/out_valid after edge N, available to the link at edge N+1.
- Throughput: one flit per cycle when out_ready is held high, including the head cycle. No bubble between the tail of one packet and the head of the next.
- in_ready depends combinationally on out_ready, out_valid, state, gnt, and in_valid/in_data (IDLE arbitration only). No combinational path from in_* to out_*.
- out_data, out_vc, and out_valid hold stable while out_valid & !out_ready.
- Simultaneous tail accept and link drain are legal in the same edge.

## Configuration
- VC0_PRIORITY_EN defined: lane 0 carries high-priority traffic.
  - In IDLE, an eligible lane 0 wins regardless of rr_ptr.
  - A lane-0 grant does not update rr_ptr at its tail; rr_ptr keeps its value.
  - Round-robin applies among lanes 1..VC-1 only.
- VC0_PRIORITY_EN undefined: lane 0 is an ordinary round-robin member and updates rr_ptr like any lane.

## Test plan
- Single packet: lane 2 sends head 0x40010005, body 0x80010000, tail 0xC0010000, with out_ready = 1. Required: three consecutive out_valid cycles with out_vc = 2, data unchanged, then busy = 0.
- Contention: lanes 1 and 3 each hold a 3-flit packet, rr_ptr = 0. Required: lane 1's packet first and uninterleaved, lane 3's packet starting the next cycle, 6 flits back-to-back.
- Backpressure: out_ready = 0 for 4 cycles mid-packet. Required: out_* held constant, all in_ready = 0, no flit lost or duplicated after release.
- Priority: lanes 0 and 1 both present heads with rr_ptr = 1.
  - VC0_PRIORITY_EN defined: lane 0 granted first and rr_ptr still 1 afterwards.
  - Undefined: lane 1 granted first.
- Protocol error: lane 3 presents body 0x80020000 while the link is idle. Required: proto_err = 1 next cycle, lane 3 never forwarded, other lanes unaffected.
- Async reset: rst low mid-packet between clock edges. Required: out_valid = 0, busy = 0, and proto_err = 0 immediately. After release, a new head on any lane is granted normally.
